// File: rtl/player_car_ctrl.sv
// Player car position controller: samples synchronized buttons once per frame,
// clamps the car to the road and runs the crash/blink/respawn sequence.
`timescale 1ns/1ps
module player_car_ctrl #(
    parameter int ROAD_LEFT    = 160,
    parameter int ROAD_RIGHT   = 480,
    parameter int CAR_W        = 32,
    parameter int START_X      = 304,
    parameter int START_Y      = 400,
    parameter int STEP         = 4,
    parameter int CRASH_FRAMES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       game_start,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       collision,
    output logic [9:0] car_x,
    output logic [9:0] car_y,
    output logic       car_visible,
    output logic       crashed
);

    typedef enum logic [1:0] {IDLE, DRIVE, CRASH} state_t;

    localparam logic [10:0] X_MIN    = 11'(ROAD_LEFT);
    localparam logic [10:0] X_MAX    = 11'(ROAD_RIGHT - CAR_W);
    localparam logic [10:0] STEP_W   = 11'(STEP);
    localparam logic [9:0]  STEP_N   = 10'(STEP);
    localparam logic [9:0]  START_XN = 10'(START_X);
    localparam logic [9:0]  START_YN = 10'(START_Y);
    localparam logic [7:0]  CNT_INIT = 8'(CRASH_FRAMES - 1);

    state_t      state_q, state_d;
    logic [9:0]  car_x_q, car_x_d;
    logic [9:0]  car_y_q, car_y_d;
    logic [7:0]  crash_cnt_q, crash_cnt_d;
    logic        car_visible_q, car_visible_d;
    logic        crashed_q, crashed_d;
    logic        l_meta_q, l_meta_d, l_sync_q, l_sync_d;
    logic        r_meta_q, r_meta_d, r_sync_q, r_sync_d;

    logic [10:0] x_ext;
    logic [10:0] x_sum;
    logic [9:0]  x_left;
    logic [9:0]  x_right;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            car_x_q       <= START_XN;
            car_y_q       <= START_YN;
            crash_cnt_q   <= '0;
            car_visible_q <= 1'b1;
            crashed_q     <= 1'b0;
            l_meta_q      <= 1'b0;
            l_sync_q      <= 1'b0;
            r_meta_q      <= 1'b0;
            r_sync_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            car_x_q       <= car_x_d;
            car_y_q       <= car_y_d;
            crash_cnt_q   <= crash_cnt_d;
            car_visible_q <= car_visible_d;
            crashed_q     <= crashed_d;
            l_meta_q      <= l_meta_d;
            l_sync_q      <= l_sync_d;
            r_meta_q      <= r_meta_d;
            r_sync_q      <= r_sync_d;
        end
    end

    // Clamped candidate positions; 11-bit compares keep the edges free of wrap-around.
    always_comb begin
        x_ext   = {1'b0, car_x_q};
        x_sum   = x_ext + STEP_W;
        x_left  = (x_ext >= X_MIN + STEP_W) ? (car_x_q - STEP_N) : X_MIN[9:0];
        x_right = (x_sum <= X_MAX) ? x_sum[9:0] : X_MAX[9:0];
    end

    always_comb begin
        state_d     = state_q;
        car_x_d     = car_x_q;
        crash_cnt_d = crash_cnt_q;
        l_meta_d    = btn_left;
        l_sync_d    = l_meta_q;
        r_meta_d    = btn_right;
        r_sync_d    = r_meta_q;
        case (state_q)
            IDLE: begin
                car_x_d = START_XN;
                if (game_start) begin
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (collision) begin
                    state_d     = CRASH;
                    crash_cnt_d = CNT_INIT;
                end else if (frame_tick && l_sync_q && !r_sync_q) begin
                    car_x_d = x_left;
                end else if (frame_tick && r_sync_q && !l_sync_q) begin
                    car_x_d = x_right;
                end
            end
            CRASH: begin
                if (frame_tick) begin
                    if (crash_cnt_q == 8'd0) begin
                        state_d = DRIVE;
                        car_x_d = START_XN;
                    end else begin
                        crash_cnt_d = crash_cnt_q - 8'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                car_x_d = START_XN;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with car_x.
    always_comb begin
        car_y_d       = START_YN;
        crashed_d     = (state_d == CRASH);
        car_visible_d = (state_d == CRASH) ? ~crash_cnt_d[2] : 1'b1;
    end

    assign car_x       = car_x_q;
    assign car_y       = car_y_q;
    assign car_visible = car_visible_q;
    assign crashed     = crashed_q;

endmodule

// File: tb/tb_player_car_ctrl.sv
// Self-checking bench for player_car_ctrl: directed vector table, hand-written
// boundary/crash sequences and a randomized run against a behavioural model.
`timescale 1ns/1ps
module tb_player_car_ctrl;

    localparam int ROAD_LEFT    = 160;
    localparam int ROAD_RIGHT   = 480;
    localparam int CAR_W        = 32;
    localparam int START_X      = 304;
    localparam int START_Y      = 400;
    localparam int STEP         = 4;
    localparam int CRASH_FRAMES = 64;

    localparam int M_IDLE  = 0;
    localparam int M_DRIVE = 1;
    localparam int M_CRASH = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       frame_tick = 1'b0;
    logic       game_start = 1'b0;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       collision = 1'b0;
    logic [9:0] car_x;
    logic [9:0] car_y;
    logic       car_visible;
    logic       crashed;

    int checks = 0;
    int errors = 0;

    // Behavioural model: game mode, position, crash frames remaining and button history.
    int   m_mode = M_IDLE;
    int   m_x = START_X;
    int   m_cnt = 0;
    logic m_lh[2] = '{1'b0, 1'b0};
    logic m_rh[2] = '{1'b0, 1'b0};

    typedef struct {
        logic rst, start, tick, left, right, coll;
        int   x;
        logic vis, cr;
    } vec_t;

    vec_t vecs[17];

    player_car_ctrl #(
        .ROAD_LEFT(ROAD_LEFT), .ROAD_RIGHT(ROAD_RIGHT), .CAR_W(CAR_W),
        .START_X(START_X), .START_Y(START_Y), .STEP(STEP),
        .CRASH_FRAMES(CRASH_FRAMES)
    ) dut (
        .clk(clk),
        .reset(reset),
        .frame_tick(frame_tick),
        .game_start(game_start),
        .btn_left(btn_left),
        .btn_right(btn_right),
        .collision(collision),
        .car_x(car_x),
        .car_y(car_y),
        .car_visible(car_visible),
        .crashed(crashed)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic rs, st, tk, lf, rt, co,
                                input int x, input logic vis, cr);
        vec_t v;
        v.rst = rs; v.start = st; v.tick = tk; v.left = lf; v.right = rt; v.coll = co;
        v.x = x; v.vis = vis; v.cr = cr;
        return v;
    endfunction

    task automatic modelStep();
        logic l_s, r_s;
        l_s = m_lh[1];
        r_s = m_rh[1];
        if (reset) begin
            m_mode = M_IDLE;
            m_x    = START_X;
            m_cnt  = 0;
            m_lh   = '{1'b0, 1'b0};
            m_rh   = '{1'b0, 1'b0};
        end else begin
            case (m_mode)
                M_IDLE: begin
                    m_x = START_X;
                    if (game_start) m_mode = M_DRIVE;
                end
                M_DRIVE: begin
                    if (collision) begin
                        m_mode = M_CRASH;
                        m_cnt  = CRASH_FRAMES - 1;
                    end else if (frame_tick && l_s && !r_s) begin
                        m_x = (m_x - STEP < ROAD_LEFT) ? ROAD_LEFT : m_x - STEP;
                    end else if (frame_tick && r_s && !l_s) begin
                        m_x = (m_x + STEP > ROAD_RIGHT - CAR_W) ? ROAD_RIGHT - CAR_W : m_x + STEP;
                    end
                end
                default: begin
                    if (frame_tick) begin
                        if (m_cnt == 0) begin
                            m_mode = M_DRIVE;
                            m_x    = START_X;
                        end else begin
                            m_cnt = m_cnt - 1;
                        end
                    end
                end
            endcase
            m_lh[1] = m_lh[0];
            m_lh[0] = btn_left;
            m_rh[1] = m_rh[0];
            m_rh[0] = btn_right;
        end
    endtask

    task automatic applyStimulus(input logic rs, st, tk, lf, rt, co);
        reset      = rs;
        game_start = st;
        frame_tick = tk;
        btn_left   = lf;
        btn_right  = rt;
        collision  = co;
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic checkOutput(input string name, input int ex, input logic ev, input logic ec);
        checks++;
        if (int'(car_x) != ex || car_visible !== ev || crashed !== ec || int'(car_y) != START_Y) begin
            errors++;
            $display("[TB] FAIL %s: got x=%0d y=%0d vis=%b cr=%b, expected x=%0d y=%0d vis=%b cr=%b",
                     name, car_x, car_y, car_visible, crashed, ex, START_Y, ev, ec);
        end
    endtask

    task automatic checkModel(input string name);
        logic ev;
        ev = (m_mode == M_CRASH) ? (((m_cnt / 4) % 2) == 0) : 1'b1;
        checkOutput(name, m_x, ev, m_mode == M_CRASH);
    endtask

    initial begin
        logic lf, rt;

        vecs[0]  = mk(1,0,0,0,0,0, 304,1,0);
        vecs[1]  = mk(0,1,1,0,0,0, 304,1,0);
        vecs[2]  = mk(0,0,0,1,0,0, 304,1,0);
        vecs[3]  = mk(0,0,0,1,0,0, 304,1,0);
        vecs[4]  = mk(0,0,1,1,0,0, 300,1,0);
        vecs[5]  = mk(0,0,0,1,0,0, 300,1,0);
        vecs[6]  = mk(0,0,1,1,0,0, 296,1,0);
        vecs[7]  = mk(0,0,1,0,1,0, 292,1,0);
        vecs[8]  = mk(0,0,1,0,1,0, 288,1,0);
        vecs[9]  = mk(0,0,1,0,1,0, 292,1,0);
        vecs[10] = mk(0,0,1,1,1,0, 296,1,0);
        vecs[11] = mk(0,0,1,1,1,0, 300,1,0);
        vecs[12] = mk(0,0,1,1,1,0, 300,1,0);
        vecs[13] = mk(0,0,1,1,0,1, 300,0,1);
        vecs[14] = mk(0,0,1,1,0,0, 300,0,1);
        vecs[15] = mk(1,0,0,1,0,0, 304,1,0);
        vecs[16] = mk(0,0,1,1,0,0, 304,1,0);

        $display("[TB] directed vector table");
        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].start, vecs[i].tick,
                          vecs[i].left, vecs[i].right, vecs[i].coll);
            checkOutput($sformatf("vec%0d", i), vecs[i].x, vecs[i].vis, vecs[i].cr);
        end

        $display("[TB] road edge clamping");
        applyStimulus(1,0,0,0,0,0);
        applyStimulus(0,1,0,0,0,0);
        applyStimulus(0,0,0,1,0,0);
        applyStimulus(0,0,0,1,0,0);
        for (int i = 0; i < 40; i++) begin
            applyStimulus(0,0,1,1,0,0);
            checkModel("left_walk");
            applyStimulus(0,0,0,1,0,0);
        end
        checkOutput("clamp_left", ROAD_LEFT, 1, 0);
        applyStimulus(0,0,0,0,1,0);
        applyStimulus(0,0,0,0,1,0);
        for (int i = 0; i < 80; i++) begin
            applyStimulus(0,0,1,0,1,0);
            checkModel("right_walk");
            applyStimulus(0,0,0,0,1,0);
        end
        checkOutput("clamp_right", ROAD_RIGHT - CAR_W, 1, 0);

        $display("[TB] short press before frame tick");
        for (int i = 0; i < 3; i++) applyStimulus(0,0,0,0,0,0);
        applyStimulus(0,0,0,1,0,0);
        applyStimulus(0,0,1,1,0,0);
        checkOutput("short_press", 448, 1, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0,0,0,0,0,0);

        $display("[TB] full crash with ignored pulses");
        applyStimulus(0,0,0,1,0,0);
        applyStimulus(0,0,0,1,0,0);
        applyStimulus(0,0,1,1,0,1);
        checkOutput("crash_entry", 448, 0, 1);
        for (int i = 0; i < CRASH_FRAMES - 1; i++) begin
            applyStimulus(0, i[0], 1, 1, 0, ~i[0]);
            checkModel("crash_blink");
            applyStimulus(0, ~i[0], 0, 1, 0, i[0]);
        end
        checkOutput("crash_last_frame", 448, 1, 1);
        applyStimulus(0,0,1,0,0,0);
        checkOutput("respawn", START_X, 1, 0);

        $display("[TB] reset during crash");
        applyStimulus(0,0,0,0,0,1);
        for (int i = 0; i < CRASH_FRAMES - 1 - 20; i++) begin
            applyStimulus(0,0,1,0,0,0);
            applyStimulus(0,0,0,0,0,0);
        end
        checkOutput("crash_cnt20", START_X, 0, 1);
        applyStimulus(1,0,0,1,0,0);
        checkOutput("reset_in_crash", START_X, 1, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0,0,1,1,0,0);
            applyStimulus(0,0,0,1,0,0);
        end
        checkOutput("idle_ignores_btn", START_X, 1, 0);

        $display("[TB] randomized run against model");
        lf = 1'b0;
        rt = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) lf = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) rt = 1'($urandom_range(0, 1));
            applyStimulus(1'($urandom_range(0, 399) == 0),
                          1'($urandom_range(0, 39) == 0),
                          1'($urandom_range(0, 5) == 0),
                          lf, rt,
                          1'($urandom_range(0, 99) == 0));
            checkModel("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
